// File: rtl/ps2_jump_receiver.sv
// PS/2 keyboard receiver: input filter, 11-bit deframer, E0/F0 prefix stripping and jump-key pulse.
// Optional macro PS2_TIMEOUT_EN adds an intra-frame timeout that raises frame_err.
module ps2_jump_receiver #(
    parameter int         SYSTEM_FREQ = 100000000,
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_US  = 1000,
    parameter logic [7:0] JUMP_CODE   = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err,
    output logic       jump,
    output logic       jump_held
);

    localparam int                FCNT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILTER_LEN - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic              clk_s1, clk_s2;
    logic              dat_s1, dat_s2;
    logic              clk_filt;
    logic [FCNT_W-1:0] fcnt;
    logic              fall_edge;

    logic [1:0]        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              par_bit;
    logic              brk_flag;
    logic              ext_flag;

`ifdef PS2_TIMEOUT_EN
    localparam int                TIMEOUT_CYCLES = SYSTEM_FREQ / 1000000 * TIMEOUT_US;
    localparam int                TCNT_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX       = TCNT_W'(TIMEOUT_CYCLES - 1);
    logic [TCNT_W-1:0]            tcnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock flips only once FILTER_LEN samples in a row disagree with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            fcnt     <= '0;
        end else if (clk_s2 == clk_filt) begin
            fcnt <= '0;
        end else if (fcnt == FILT_MAX) begin
            clk_filt <= clk_s2;
            fcnt     <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign fall_edge = clk_filt && !clk_s2 && (fcnt == FILT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            brk_flag    <= 1'b0;
            ext_flag    <= 1'b0;
            scan_code   <= '0;
            scan_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            jump        <= 1'b0;
            jump_held   <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            scan_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            jump       <= 1'b0;
            if (fall_edge) begin
`ifdef PS2_TIMEOUT_EN
                tcnt <= '0;
`endif
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg[bit_cnt] <= dat_s2;
                        if (bit_cnt == 3'd7) state <= PARITY;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        // Stop-bit error wins over parity error; either one drops pending prefixes.
                        if (!dat_s2) begin
                            frame_err <= 1'b1;
                            brk_flag  <= 1'b0;
                            ext_flag  <= 1'b0;
                        end else if (!(^{shift_reg, par_bit})) begin
                            parity_err <= 1'b1;
                            brk_flag   <= 1'b0;
                            ext_flag   <= 1'b0;
                        end else if (shift_reg == 8'hE0) begin
                            ext_flag <= 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            brk_flag <= 1'b1;
                        end else begin
                            scan_code   <= shift_reg;
                            is_break    <= brk_flag;
                            is_extended <= ext_flag;
                            scan_valid  <= 1'b1;
                            brk_flag    <= 1'b0;
                            ext_flag    <= 1'b0;
                            if (shift_reg == JUMP_CODE && !ext_flag) begin
                                if (brk_flag) begin
                                    jump_held <= 1'b0;
                                end else if (!jump_held) begin
                                    jump      <= 1'b1;
                                    jump_held <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            else if (state != IDLE) begin
                if (tcnt == TCNT_MAX) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    brk_flag  <= 1'b0;
                    ext_flag  <= 1'b0;
                    tcnt      <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: doc/ps2_jump_receiver.md
Name: ps2_jump_receiver

Overview:
- PS/2 device-to-host receiver for the keyboard on ps2_clk/ps2_data.
- Filters and synchronizes the bus, deframes 11-bit PS/2 frames and checks parity and stop bit.
- Strips E0/F0 prefixes and reports each scan code with break/extended qualifiers.
- Turns make/break of the jump key into the single-cycle `jump` pulse the game controller consumes.

Parameters:
SYSTEM_FREQ, 100000000, clk frequency in Hz.
FILTER_LEN, 8, consecutive equal samples needed before filtered ps2_clk changes.
TIMEOUT_US, 1000, max gap between falling edges inside a frame, in microseconds.
JUMP_CODE, 8'h29, set-2 make code of the jump key (spacebar).

Ports:
clk  input  1  100 MHz system clock
reset  input  1  synchronous, active-low reset (0 = reset)
ps2_clk  input  1  raw PS/2 clock from the keyboard
ps2_data  input  1  raw PS/2 data from the keyboard
scan_code  output  8  last reported non-prefix scan code
scan_valid  output  1  one-cycle strobe; scan_code/is_break/is_extended valid
is_break  output  1  reported code was preceded by F0
is_extended  output  1  reported code was preceded by E0
parity_err  output  1  one-cycle strobe on odd-parity failure
frame_err  output  1  one-cycle strobe on bad stop bit or timeout
jump  output  1  one-cycle strobe on a fresh (non-repeat) make of JUMP_CODE
jump_held  output  1  level; jump key currently down

Behaviour:
- Reset: sampled on a clk edge with reset==0. Reset has priority over every event.
  - All outputs go to 0.
  - FSM goes to IDLE; prefix flags, shift register and counters clear.
  - Filtered clock is set to 1.
  - Reset mid-frame discards the partial frame silently.
- Input conditioning:
  - Each of ps2_clk and ps2_data passes through 2 flops.
  - Filtered clock takes the synchronized value only after FILTER_LEN consecutive identical samples.
  - Falling edge = filtered clock goes 1->0. The synchronized data is sampled in that same cycle.
- FSM (advances only on a falling edge, except timeout):
  - IDLE: sample 0 -> DATA with bit count 0. Sample 1 -> stay in IDLE, no error.
  - DATA: shift sample into bit[count], LSB first. After the 8th bit -> PARITY.
  - PARITY: store sample -> STOP.
  - STOP -> IDLE. The frame is good if stop==1 and popcount(data)+parity is odd.
    - stop==0: frame_err pulse, data discarded.
    - Parity bad with stop good: parity_err pulse, data discarded.
    - Both strobes never fire together; a stop error takes precedence.
- Timeout (under PS2_TIMEOUT_EN):
  - A counter resets on every falling edge and counts while the FSM is not in IDLE.
  - Reaching SYSTEM_FREQ/1000000*TIMEOUT_US cycles (100000 by default) -> frame_err pulse and go to IDLE.
  - Counter width must hold that value.
- Good-frame decode. All strobes assert in the cycle after the edge that sampled the stop bit and last exactly 1 cycle.
  - Byte E0: set ext flag; no scan_valid.
  - Byte F0: set brk flag; no scan_valid.
  - Any other byte:
    - scan_code <= byte, is_break <= brk, is_extended <= ext, scan_valid pulse.
    - Both flags then clear.
    - scan_code/is_break/is_extended hold until the next report.
  - Any parity_err/frame_err clears both prefix flags.
- Jump logic, evaluated on a report:
  - byte==JUMP_CODE, !brk, !ext, jump_held==0: jump pulse (same cycle as scan_valid), jump_held <= 1.
  - Same but jump_held==1 (typematic repeat): no pulse.
  - byte==JUMP_CODE, brk, !ext: jump_held <= 0, no pulse.
  - Extended codes never affect jump.
- Back-to-back frames with minimum bus idle must be accepted; no frame is dropped while strobes are asserted.

Optional Feature:
PS2_TIMEOUT_EN:
- Defined: the intra-frame timeout counter and its frame_err source are present.
- Undefined: no counter is built. The FSM waits indefinitely for edges, and frame_err comes only from a bad stop bit.

Test Plan:
- Make frame 0x29: bits 0,1001_0100 (LSB first), parity 0, stop 1, 12.5 kHz bus -> scan_valid=1, scan_code=29, is_break=0, jump=1 for one cycle, jump_held=1.
- Second 0x29 frame (typematic) -> scan_valid=1, jump stays 0, jump_held stays 1. Then F0 (parity 1) followed by 29 -> exactly one scan_valid, is_break=1, jump_held=0.
- E0 then 0x29 -> scan_valid, is_extended=1, scan_code=29; jump stays 0 and jump_held stays unchanged.
- Frame 0x1C sent with parity bit 1 -> parity_err one cycle, no scan_valid. The next good 0x1C reports is_break=0 and is_extended=0.
- Frame with stop=0 -> frame_err, no scan_valid. A separate frame halted after 4 data bits -> frame_err exactly 100000 cycles after the last edge with PS2_TIMEOUT_EN, never without it.
- 1-cycle and 5-cycle glitches on ps2_clk inside a 0x29 frame -> ignored, frame decodes correctly. reset=0 asserted mid-frame -> all outputs 0, and the next full frame decodes.
